// File: rtl/seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : seq_checker
// Brief    : Frame-based checker of a serial truth-table bit stream with
//            resync, per-frame error counting and error-rate alarm.
// Revision : 1.0 - initial release
// ============================================================================
module seq_checker #(
    parameter logic [7:0] TRUTH_TABLE = 8'b00111001,
    parameter int         FRAME_LEN   = 10,
    parameter int         ERR_LIMIT   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic       z_in,
    input  logic [3:0] idx,
    output logic       match,
    output logic       err_flag,
    output logic [3:0] err_count,
    output logic       frame_done,
    output logic [3:0] frame_errors,
    output logic       alarm,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_LOST  = 2'b10,
        ST_ALARM = 2'b11
    } state_t;

    localparam logic [4:0] C_FRAME_LEN = 5'(FRAME_LEN);
    localparam logic [3:0] C_LAST_IDX  = 4'(FRAME_LEN - 1);
    localparam logic [4:0] C_ERR_LIMIT = 5'(ERR_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] exp_idx_q, exp_idx_d;
    logic       match_q, match_d;
    logic       err_flag_q, err_flag_d;
    logic [3:0] err_count_q, err_count_d;
    logic       frame_done_q, frame_done_d;
    logic [3:0] frame_errors_q, frame_errors_d;
    logic       alarm_q, alarm_d;

    logic       w_mismatch;
    logic       w_in_range;
    logic       w_compare;
    logic [3:0] w_count_next;

    assign w_mismatch   = z_in ^ TRUTH_TABLE[idx[2:0]];
    assign w_in_range   = {1'b0, idx} < C_FRAME_LEN;
    assign w_count_next = (err_count_q == 4'hF) ? 4'hF : err_count_q + {3'b000, w_mismatch};

    always_comb begin
        state_d        = state_q;
        exp_idx_d      = exp_idx_q;
        err_count_d    = err_count_q;
        frame_done_d   = 1'b0;
        frame_errors_d = frame_errors_q;
        alarm_d        = alarm_q;
        w_compare      = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOST: begin
                // Resync only on the start of a frame; alarm survives a loss of lock.
                if (sample_valid && idx == 4'd0) begin
                    w_compare   = 1'b1;
                    state_d     = alarm_q ? ST_ALARM : ST_CHECK;
                    exp_idx_d   = 4'd1;
                    err_count_d = w_count_next;
                end
            end
            default: begin
                if (sample_valid) begin
                    if (!w_in_range || idx != exp_idx_q) begin
                        state_d     = ST_LOST;
                        err_count_d = 4'd0;
                        exp_idx_d   = 4'd0;
                    end else begin
                        w_compare = 1'b1;
                        if (idx == C_LAST_IDX) begin
                            frame_done_d   = 1'b1;
                            frame_errors_d = w_count_next;
                            err_count_d    = 4'd0;
                            exp_idx_d      = 4'd0;
                            if ({1'b0, w_count_next} >= C_ERR_LIMIT) begin
                                alarm_d = 1'b1;
                                state_d = ST_ALARM;
                            end else if (w_count_next == 4'd0) begin
                                alarm_d = 1'b0;
                                state_d = ST_CHECK;
                            end
                        end else begin
                            exp_idx_d   = exp_idx_q + 4'd1;
                            err_count_d = w_count_next;
                        end
                    end
                end
            end
        endcase

        match_d    = w_compare & ~w_mismatch;
        err_flag_d = w_compare & w_mismatch;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            exp_idx_q      <= 4'd0;
            match_q        <= 1'b0;
            err_flag_q     <= 1'b0;
            err_count_q    <= 4'd0;
            frame_done_q   <= 1'b0;
            frame_errors_q <= 4'd0;
            alarm_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            exp_idx_q      <= exp_idx_d;
            match_q        <= match_d;
            err_flag_q     <= err_flag_d;
            err_count_q    <= err_count_d;
            frame_done_q   <= frame_done_d;
            frame_errors_q <= frame_errors_d;
            alarm_q        <= alarm_d;
        end
    end

    assign match        = match_q;
    assign err_flag     = err_flag_q;
    assign err_count    = err_count_q;
    assign frame_done   = frame_done_q;
    assign frame_errors = frame_errors_q;
    assign alarm        = alarm_q;
    assign state        = state_q;

endmodule
`default_nettype wire

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter TRUTH_TABLE, default 8'b00111001, expected output bit for 3-bit index x (bit x of TRUTH_TABLE).
REQ-002 Parameter FRAME_LEN, default 10, samples per frame; legal range 2..16.
REQ-003 Parameter ERR_LIMIT, default 3, per-frame error count that raises alarm.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_valid  in  1  z_in/idx carry a sample this cycle.
REQ-007 z_in  in  1  serial function bit from the upstream generator.
REQ-008 idx  in  4  upstream step counter value (0..FRAME_LEN-1) that produced z_in.
REQ-009 match  out  1  registered pulse: accepted sample equalled expected bit.
REQ-010 err_flag  out  1  registered pulse: accepted sample differed from expected bit.
REQ-011 err_count  out  4  running mismatch count in current frame, saturating at 15.
REQ-012 frame_done  out  1  one-cycle pulse at frame completion.
REQ-013 frame_errors  out  4  mismatch count of last completed frame.
REQ-014 alarm  out  1  error-rate alarm, level.
REQ-015 state  out  2  FSM state: IDLE=00, CHECK=01, LOST=10, ALARM=11.

Function
REQ-016 Expected bit SHALL be TRUTH_TABLE[idx[2:0]] (idx 8,9 map to 0,1).
REQ-017 Internal exp_idx counter (4 bits) SHALL track next expected idx, wrapping FRAME_LEN-1 -> 0.
REQ-018 A sample SHALL be accepted only when sample_valid=1 and state is CHECK or ALARM; cycles with sample_valid=0 change nothing except clearing match/err_flag/frame_done.
REQ-019 match/err_flag SHALL assert exactly one cycle after an accepted sample (latency 1), never both.
REQ-020 IDLE: wait for sample_valid=1 with idx=0; that sample SHALL be accepted (compared) and state -> CHECK, exp_idx=1.
REQ-021 CHECK/ALARM: accepted sample with idx != exp_idx or idx >= FRAME_LEN is a discontinuity: no compare, no match/err_flag, err_count cleared, state -> LOST.
REQ-022 LOST: behaves as IDLE (resync on idx=0 sample -> CHECK, that sample compared); alarm value SHALL be held, and resync SHALL go to ALARM if alarm=1.
REQ-023 Mismatch SHALL increment err_count, saturating at 15.
REQ-024 On accepted sample with idx=FRAME_LEN-1: next cycle frame_done=1, frame_errors = err_count including this sample's result, err_count = 0.
REQ-025 At frame end, frame total >= ERR_LIMIT SHALL set alarm=1, state -> ALARM.
REQ-026 At frame end in ALARM, frame total = 0 SHALL clear alarm, state -> CHECK; otherwise remain ALARM.
REQ-027 Frame total between 1 and ERR_LIMIT-1 in CHECK SHALL leave state CHECK, alarm=0.
REQ-028 All outputs SHALL be registered; no combinational path input -> output.

Reset
REQ-029 reset=1 at a clock edge SHALL force state=IDLE, exp_idx=0, match=0, err_flag=0, err_count=0, frame_done=0, frame_errors=0, alarm=0, overriding any sample that cycle.
REQ-030 Reset asserted mid-frame SHALL discard partial counts; first post-reset accepted sample requires idx=0.

Verification
REQ-031 Reset, then 3 clean frames idx 0..9 with z = 1,0,0,1,1,1,0,0,1,0 -> 30 match pulses, 0 err_flag, 3 frame_done pulses, frame_errors=0, state=01.
REQ-032 One frame with z inverted at idx 3 and 5 -> err_flag cycles after those samples, err_count 1 then 2, frame_errors=2, alarm=0, state=01.
REQ-033 Frame with 4 inverted bits -> frame_errors=4, alarm=1, state=11; next clean frame -> frame_errors=0, alarm=0, state=01.
REQ-034 Mid-frame idx jump 4 -> 7 -> no compare on idx-7 sample, err_count=0, state=10; next idx=0 sample -> state=01, compare resumes.
REQ-035 Start stimulus at idx=6 after reset -> samples ignored, state=00 until idx=0; sample_valid gaps mid-frame -> no outputs, exp_idx held.
REQ-036 reset pulse while err_count=2 at idx 5 -> all outputs 0, state=00 next cycle.
